// File: rtl/baud_tick_gen.sv
// Purpose : fractional phase-accumulator baud generator; os_tick at baud*OVERSAMPLE, bit_tick per bit, square-wave baud_clk.
// Latency : os_tick registered one clock after the overflowing add; bit_tick coincident with the os_tick that wraps os_count.
// Backpressure: none; enable=0 freezes the phase, resync or a rate change restarts it from zero.
`timescale 1ns/1ps
module baud_tick_gen #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned ACC_WIDTH   = 24,
    parameter int unsigned DEFAULT_SEL = 0
) (
    input  logic                          clk50MHz,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [2:0]                    baud_sel,
    input  logic                          resync,
    output logic                          os_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_count,
    output logic                          baud_clk,
    output logic                          sel_err
);

    localparam int CW = $clog2(OVERSAMPLE);

    // Phase increment for a given bit rate, rounded to nearest:
    // round(rate * OVERSAMPLE * 2^ACC_WIDTH / CLK_HZ), done in 64-bit integer math.
    function automatic logic [ACC_WIDTH-1:0] calc_inc(input longint unsigned rate);
        longint unsigned num;
        longint unsigned q;
        num = (rate * 64'(OVERSAMPLE)) << ACC_WIDTH;
        q   = (64'd2 * num + 64'(CLK_HZ)) / (64'd2 * 64'(CLK_HZ));
        return ACC_WIDTH'(q);
    endfunction

    // Codes 6 and 7 are reserved and fall back to the 9600 increment.
    localparam logic [ACC_WIDTH-1:0] INC_TAB [0:7] = '{
        calc_inc(64'd9600),
        calc_inc(64'd19200),
        calc_inc(64'd38400),
        calc_inc(64'd57600),
        calc_inc(64'd115200),
        calc_inc(64'd230400),
        calc_inc(64'd9600),
        calc_inc(64'd9600)
    };

    logic [2:0]           sel_q;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] inc_cur;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 sel_change;
    logic                 last_sub;

    // Increment selected by the latched code; a new code only takes effect the edge after it is latched.
    assign inc_cur    = INC_TAB[sel_q];
    assign sum        = {1'b0, acc} + {1'b0, inc_cur};
    assign carry      = sum[ACC_WIDTH];
    assign last_sub   = (os_count == CW'(OVERSAMPLE - 1));
    // resync outranks a selection change, so a code change seen together with resync is latched one edge later.
    assign sel_change = !resync && (baud_sel != sel_q);
    assign baud_clk   = os_count[CW-1];

    // Latch the rate code and flag reserved codes while they are held.
    always_ff @(posedge clk50MHz or negedge reset_n) begin
        if (!reset_n) begin
            sel_q   <= 3'(DEFAULT_SEL);
            sel_err <= 1'b0;
        end else if (sel_change) begin
            sel_q   <= baud_sel;
            sel_err <= baud_sel[2] & baud_sel[1];
        end
    end

    // Phase accumulator, oversample counter and tick pulses; clears on resync and on any rate change.
    always_ff @(posedge clk50MHz or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            os_count <= '0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
        end else if (resync || sel_change) begin
            acc      <= '0;
            os_count <= '0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
        end else if (!enable) begin
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            acc      <= sum[ACC_WIDTH-1:0];
            os_tick  <= carry;
            bit_tick <= carry && last_sub;
            if (carry) begin
                os_count <= os_count + CW'(1);
            end
        end
    end

endmodule
